// File: rtl/hk628_voice_sched.sv
// hk628_voice_sched -- voice scheduler for the HK628 sound-toy audio path.
//
// Turns the eight button inputs into sound triggers, allocates them to NVOICE
// playback slots, and once per sample period fetches one byte per active slot
// from the shared sample ROM and mixes the bytes into a 16-bit PCM word.
//
// Optional feature: define HK628_LOWBATT_EN to make low_batt double the sample
// period (halving the pitch). Without it low_batt is ignored.
//
// Ports:
//   clk       core clock
//   reset     asynchronous active-high reset
//   btn       raw button levels (asynchronous to clk)
//   low_batt  low-battery request (only used with HK628_LOWBATT_EN)
//   rom_req   ROM read request; rom_addr stable until rom_ack
//   rom_addr  {sound_id[2:0], offset[OFS_W-1:0]}
//   rom_ack   ROM read complete, rom_data valid in the same cycle
//   rom_data  signed sample byte (8'h80 = end-of-sound marker)
//   pcm_out   mixed signed PCM
//   active    per-slot playing flags
//   busy      scheduler FSM is not idle
//   overrun   sticky: a sample tick arrived while the FSM was busy
module hk628_voice_sched #(
  parameter int NVOICE     = 4,
  parameter int OFS_W      = 13,
  parameter int SAMPLE_DIV = 1134
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        btn,
  input  logic              low_batt,
  output logic              rom_req,
  output logic [OFS_W+2:0]  rom_addr,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
  output logic [15:0]       pcm_out,
  output logic [NVOICE-1:0] active,
  output logic              busy,
  output logic              overrun
);

  localparam int VW    = $clog2(NVOICE);
  localparam int ACC_W = 8 + VW;
  localparam int CNT_W = $clog2(2 * SAMPLE_DIV + 1);

  typedef enum logic [1:0] {IDLE, ALLOC, FETCH, MIX} state_t;

  state_t state, state_nx;

  // ---------------------------------------------------------------------------
  // Button capture: 2-FF synchroniser, rising-edge detect, pending requests
  // ---------------------------------------------------------------------------
  logic [7:0] btn_s1, btn_s2, btn_d;
  logic [7:0] btn_rise;
  logic [7:0] pending;
  logic [7:0] clr_mask;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_d  <= '0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
    end
  end

  assign btn_rise = btn_s2 & ~btn_d;

  // ---------------------------------------------------------------------------
  // Sample-period divider
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] limit;
  logic             tick;

`ifdef HK628_LOWBATT_EN
  assign limit = low_batt ? CNT_W'(2 * SAMPLE_DIV) : CNT_W'(SAMPLE_DIV);
`else
  logic unused_low_batt;
  assign unused_low_batt = low_batt;
  assign limit = CNT_W'(SAMPLE_DIV);
`endif

  assign tick = (div_cnt == limit - CNT_W'(1));

  // ">=" also catches a count left above a freshly shortened limit, which
  // wraps to zero without producing a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt >= limit - CNT_W'(1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Slot state and allocation
  // ---------------------------------------------------------------------------
  logic [NVOICE-1:0] slot_act;
  logic [2:0]        slot_snd [NVOICE];
  logic [OFS_W-1:0]  slot_ofs [NVOICE];
  logic [VW-1:0]     steal_ptr;
  logic [VW-1:0]     vidx;
  logic [ACC_W-1:0]  acc;

  logic          pick_vld;
  logic [2:0]    pick_snd;
  logic          hit_vld, free_vld;
  logic [VW-1:0] hit_idx, free_idx, target;

  always_comb begin
    pick_vld = 1'b0;
    pick_snd = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (pending[i] && !pick_vld) begin
        pick_vld = 1'b1;
        pick_snd = 3'(i);
      end
    end
  end

  always_comb begin
    hit_vld  = 1'b0;
    hit_idx  = '0;
    free_vld = 1'b0;
    free_idx = '0;
    for (int unsigned j = 0; j < NVOICE; j++) begin
      if (slot_act[j] && (slot_snd[j] == pick_snd) && !hit_vld) begin
        hit_vld = 1'b1;
        hit_idx = VW'(j);
      end
      if (!slot_act[j] && !free_vld) begin
        free_vld = 1'b1;
        free_idx = VW'(j);
      end
    end
  end

  // Retrigger beats a free slot, which beats stealing.
  assign target = hit_vld ? hit_idx : (free_vld ? free_idx : steal_ptr);

  assign clr_mask = ((state == ALLOC) && pick_vld) ? (8'b1 << pick_snd) : '0;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic cur_act;
  logic slot_done;
  logic last_slot;

  assign cur_act   = slot_act[vidx];
  assign slot_done = !cur_act || rom_ack;
  assign last_slot = (vidx == VW'(NVOICE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (tick) state_nx = ALLOC;
      ALLOC:   state_nx = FETCH;
      FETCH:   if (slot_done && last_slot) state_nx = MIX;
      MIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Combinational from state so that reset drops the request immediately.
  assign rom_req  = (state == FETCH) && cur_act;
  assign rom_addr = rom_req ? {slot_snd[vidx], slot_ofs[vidx]} : '0;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      overrun   <= 1'b0;
      slot_act  <= '0;
      steal_ptr <= '0;
      vidx      <= '0;
      acc       <= '0;
      pcm_out   <= '0;
      for (int unsigned v = 0; v < NVOICE; v++) begin
        slot_snd[v] <= '0;
        slot_ofs[v] <= '0;
      end
    end else begin
      // A new edge overrides a same-cycle clear of the same bit.
      pending <= (pending & ~clr_mask) | btn_rise;

      if (tick && (state != IDLE)) begin
        overrun <= 1'b1;
      end

      unique case (state)
        ALLOC: begin
          if (pick_vld) begin
            slot_act[target] <= 1'b1;
            slot_snd[target] <= pick_snd;
            slot_ofs[target] <= '0;
            if (!hit_vld && !free_vld) begin
              steal_ptr <= steal_ptr + VW'(1);
            end
          end
          vidx <= '0;
          acc  <= '0;
        end
        FETCH: begin
          if (rom_req && rom_ack) begin
            if (rom_data == 8'h80) begin
              slot_act[vidx] <= 1'b0;
            end else begin
              acc            <= acc + {{VW{rom_data[7]}}, rom_data};
              slot_ofs[vidx] <= slot_ofs[vidx] + OFS_W'(1);
              if (&slot_ofs[vidx]) begin
                slot_act[vidx] <= 1'b0;
              end
            end
          end
          // NVOICE is a power of two, so vidx rolls back to 0 after the last slot.
          if (slot_done) begin
            vidx <= vidx + VW'(1);
          end
        end
        MIX: begin
          pcm_out <= {acc, {(8 - VW){1'b0}}};
        end
        default: ;
      endcase
    end
  end

  assign active = slot_act;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_hk628_voice_sched.sv
module tb_hk628_voice_sched;

  localparam int NV  = 4;
  localparam int VW  = 2;
  localparam int OW  = 4;
  localparam int DIV = 80;
  localparam int REG = 1 << OW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    btn = '0;
  logic          low_batt = 1'b0;
  logic          rom_req;
  logic [OW+2:0] rom_addr;
  logic          rom_ack = 1'b0;
  logic [7:0]    rom_data = '0;
  logic [15:0]   pcm_out;
  logic [NV-1:0] active;
  logic          busy;
  logic          overrun;

  hk628_voice_sched #(.NVOICE(NV), .OFS_W(OW), .SAMPLE_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .btn(btn), .low_batt(low_batt),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
    .pcm_out(pcm_out), .active(active), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Sample ROM contents, shared by the ROM responder and the reference model.
  logic [7:0] rom_mem [0:8*REG-1];
  int  max_wait = 0;
  bit  stall = 1'b0;

  // Reference model: per-period behaviour of the scheduler.
  bit [7:0] m_pend = '0;
  bit       m_act [NV];
  int       m_snd [NV];
  int       m_ofs [NV];
  int       m_steal = 0;

  typedef struct {
    logic [15:0]   pcm;
    logic [NV-1:0] act;
  } exp_t;
  exp_t sb_q[$];

  int periods_done = 0;
  int rise_cnt = 0;
  int last_rise_cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic void model_reset();
    m_pend  = '0;
    m_steal = 0;
    for (int v = 0; v < NV; v++) begin
      m_act[v] = 1'b0;
      m_snd[v] = 0;
      m_ofs[v] = 0;
    end
    sb_q.delete();
  endfunction

  function automatic void model_period();
    int   acc = 0;
    int   s = -1;
    int   tgt = -1;
    exp_t e;
    logic signed [7:0] sd;
    for (int i = 0; i < 8; i++)
      if (s < 0 && m_pend[i]) s = i;
    if (s >= 0) begin
      m_pend[s] = 1'b0;
      for (int v = 0; v < NV; v++)
        if (tgt < 0 && m_act[v] && m_snd[v] == s) tgt = v;
      for (int v = 0; v < NV; v++)
        if (tgt < 0 && !m_act[v]) tgt = v;
      if (tgt < 0) begin
        tgt = m_steal;
        m_steal = (m_steal + 1) % NV;
      end
      m_act[tgt] = 1'b1;
      m_snd[tgt] = s;
      m_ofs[tgt] = 0;
    end
    for (int v = 0; v < NV; v++) begin
      if (m_act[v]) begin
        sd = rom_mem[m_snd[v] * REG + m_ofs[v]];
        if (sd == -8'sd128) begin
          m_act[v] = 1'b0;
        end else begin
          acc += int'(sd);
          m_ofs[v]++;
          if (m_ofs[v] == REG) m_act[v] = 1'b0;
        end
      end
    end
    e.pcm = 16'(acc * (1 << (8 - VW)));
    for (int v = 0; v < NV; v++) e.act[v] = m_act[v];
    sb_q.push_back(e);
  endfunction

  initial forever @(posedge clk) cyc++;

  // Stimulus side: each time a sample period starts, the model's expected
  // result for that period is queued.
  initial begin
    bit prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (busy && !prev) begin
          model_period();
          rise_cnt++;
          last_rise_cyc = cyc;
        end
        prev = busy;
      end
    end
  end

  // Monitor: when a period finishes, compare the mixed output with the queue.
  initial begin
    bit   prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b0;
      end else begin
        if (!busy && prev) begin
          tests++;
          if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL sb_empty: period ended with pcm=%0h but no expected entry", pcm_out);
          end else begin
            e = sb_q.pop_front();
            if (pcm_out !== e.pcm || active !== e.act) begin
              fails++;
              $display("FAIL period_%0d: got pcm=%0h active=%b, expected pcm=%0h active=%b",
                       periods_done, pcm_out, active, e.pcm, e.act);
            end
          end
          periods_done++;
        end
        prev = busy;
      end
    end
  end

  // ROM responder with random wait states, plus handshake stability check.
  initial begin
    int            w = 0;
    bit            hs_pend = 1'b0;
    logic [OW+2:0] p_addr = '0;
    forever begin
      @(negedge clk);
      if (!reset && hs_pend) begin
        tests++;
        if (rom_req !== 1'b1 || rom_addr !== p_addr) begin
          fails++;
          $display("FAIL rom_hold: got req=%b addr=%0h, expected req=1 addr=%0h",
                   rom_req, rom_addr, p_addr);
        end
      end
      if (reset || !rom_req) begin
        rom_ack  = 1'b0;
        rom_data = 8'($urandom);
      end else if (stall) begin
        rom_ack  = 1'b0;
        rom_data = 8'($urandom);
      end else if (w == 0) begin
        rom_ack  = 1'b1;
        rom_data = rom_mem[rom_addr];
        w = $urandom_range(0, max_wait);
      end else begin
        w--;
        rom_ack  = 1'b0;
        rom_data = 8'($urandom);
      end
      hs_pend = !reset && rom_req && !rom_ack;
      p_addr  = rom_addr;
    end
  end

  task automatic press(input logic [7:0] m);
    @(negedge clk);
    btn = m;
    m_pend |= m;
    repeat (4) @(negedge clk);
    btn = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_periods(input int n);
    int target = periods_done + n;
    int budget = n * 4 * DIV + 100;
    while (periods_done < target && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    tests++;
    if (periods_done < target) begin
      fails++;
      $display("FAIL wait_periods: got %0d periods, expected %0d", periods_done, target);
    end
  endtask

  task automatic wait_rise(output int t);
    int target = rise_cnt + 1;
    int budget = 4 * DIV + 100;
    while (rise_cnt < target && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    tests++;
    if (rise_cnt < target) begin
      fails++;
      $display("FAIL wait_rise: got no period start, expected one within budget");
    end
    t = last_rise_cyc;
  endtask

  task automatic fill_region(input int s, input bit allow_end);
    logic [7:0] d;
    for (int k = 0; k < REG; k++) begin
      d = 8'($urandom);
      if (!allow_end && d == 8'h80) d = 8'h7F;
      rom_mem[s * REG + k] = d;
    end
  endtask

  initial begin
    int t0, t1, exp_sp, budget;
    logic [15:0] hold;

    for (int s = 0; s < 8; s++) begin
      fill_region(s, 1'b0);
      for (int k = 0; k < REG; k++)
        if ($urandom_range(0, 11) == 0) rom_mem[s * REG + k] = 8'h80;
    end
    rom_mem[2 * REG + 0] = 8'd10;
    rom_mem[2 * REG + 1] = 8'd20;
    rom_mem[2 * REG + 2] = 8'd30;
    rom_mem[2 * REG + 3] = 8'h80;
    model_reset();

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_pcm", 32'(pcm_out), 0);
    check("rst_active", 32'(active), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_rom_req", 32'(rom_req), 0);
    check("rst_rom_addr", 32'(rom_addr), 0);
    reset = 1'b0;

    // Single sound with end marker, zero-wait ROM
    press(8'h04);
    wait_periods(1);
    check("snd2_p1_pcm", 32'(pcm_out), 640);
    check("snd2_p1_act", 32'(active), 1);
    wait_periods(1);
    check("snd2_p2_pcm", 32'(pcm_out), 1280);
    wait_periods(1);
    check("snd2_p3_pcm", 32'(pcm_out), 1920);
    wait_periods(1);
    check("snd2_p4_pcm", 32'(pcm_out), 0);
    check("snd2_p4_act", 32'(active), 0);

    // Five simultaneous presses: one allocation per period, fifth steals slot 0
    for (int s = 0; s < 6; s++) fill_region(s, 1'b0);
    max_wait = 2;
    press(8'h1F);
    wait_periods(4);
    check("five_p4_act", 32'(active), 32'hF);
    wait_periods(1);
    check("five_p5_act", 32'(active), 32'hF);
    // Retrigger sound 1 in its slot, then a further steal takes slot 1
    press(8'h02);
    wait_periods(1);
    press(8'h20);
    wait_periods(2);

    // Randomised presses and ROM wait states
    max_wait = 3;
    for (int it = 0; it < 120; it++) begin
      if ($urandom_range(0, 1) == 1)
        press(8'($urandom_range(0, 255) & $urandom_range(0, 255)));
      wait_periods(1);
    end

    // Sample-tick spacing with and without low_batt
    low_batt = 1'b1;
    wait_rise(t0);
    wait_rise(t0);
    wait_rise(t1);
`ifdef HK628_LOWBATT_EN
    exp_sp = 2 * DIV;
`else
    exp_sp = DIV;
`endif
    check("tick_spacing_lowbatt", 32'(t1 - t0), 32'(exp_sp));
    low_batt = 1'b0;
    wait_rise(t0);
    wait_rise(t0);
    wait_rise(t1);
    check("tick_spacing_normal", 32'(t1 - t0), 32'(DIV));
    wait_periods(1);

    // Overrun: ROM stalls for two sample periods
    check("overrun_clear", 32'(overrun), 0);
    fill_region(7, 1'b0);
    press(8'h80);
    wait_periods(1);
    hold = pcm_out;
    stall = 1'b1;
    budget = 4 * DIV;
    while (!(busy && rom_req) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("stall_req_seen", 32'(rom_req), 1);
    repeat (2 * DIV) @(negedge clk);
    check("stall_busy", 32'(busy), 1);
    check("stall_pcm_hold", 32'(pcm_out), 32'(hold));
    check("stall_overrun", 32'(overrun), 1);
    stall = 1'b0;
    wait_periods(2);
    check("overrun_sticky", 32'(overrun), 1);

    // Reset while a ROM request is outstanding
    rom_mem[3 * REG + 0] = 8'd5;
    rom_mem[3 * REG + 1] = 8'd6;
    stall = 1'b1;
    budget = 4 * DIV;
    while (!rom_req && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("pre_reset_req", 32'(rom_req), 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_reset_req", 32'(rom_req), 0);
    check("mid_reset_active", 32'(active), 0);
    check("mid_reset_pcm", 32'(pcm_out), 0);
    check("mid_reset_overrun", 32'(overrun), 0);
    stall = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    press(8'h08);
    wait_periods(1);
    check("after_reset_p1_pcm", 32'(pcm_out), 320);
    check("after_reset_p1_act", 32'(active), 1);
    wait_periods(1);
    check("after_reset_p2_pcm", 32'(pcm_out), 384);
    check("sb_drained", 32'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    fails++;
    $display("FAIL watchdog: got no completion by %0t, expected bench to finish", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
